// File: rtl/fwd_ctrl_unit.sv
// rtl/fwd_ctrl_unit.sv - forwarding select and load-use stall controller (optional FWD_STATS_EN statistics counters)
module fwd_ctrl_unit #(
  parameter int REG_AW = 5
`ifdef FWD_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
`ifdef FWD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] fwd_cnt
`endif
);

  // WB producers need no slot: the register file writes before it reads.
  logic              ex_we_q, ex_we_d;
  logic              ex_load_q, ex_load_d;
  logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
  logic              mem_we_q;
  logic [REG_AW-1:0] mem_dst_q;
  logic [1:0]        fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0]        fwd_b_sel_q, fwd_b_sel_d;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic haz, bubble;

  // Producer matches; register 0 is never a valid producer.
  assign ex_hit_rs  = ex_we_q  & (ex_dst_q  != '0) & (id_rs == ex_dst_q);
  assign ex_hit_rt  = ex_we_q  & (ex_dst_q  != '0) & (id_rt == ex_dst_q);
  assign mem_hit_rs = mem_we_q & (mem_dst_q != '0) & (id_rs == mem_dst_q);
  assign mem_hit_rt = mem_we_q & (mem_dst_q != '0) & (id_rt == mem_dst_q);

  assign haz    = id_valid & ex_load_q &
                  ((id_use_rs & ex_hit_rs) | (id_use_rt & ex_hit_rt));
  assign stall  = haz & ~flush;
  assign bubble = stall | flush | ~id_valid;

  // Next EX slot and operand selects; nearest producer (EX) wins over MEM.
  always_comb begin
    ex_we_d     = 1'b0;
    ex_load_d   = 1'b0;
    ex_dst_d    = '0;
    fwd_a_sel_d = 2'd0;
    fwd_b_sel_d = 2'd0;
    if (!bubble) begin
      ex_we_d   = id_we;
      ex_load_d = id_load;
      ex_dst_d  = id_dst;
      if (id_use_rs && ex_hit_rs)       fwd_a_sel_d = 2'd1;
      else if (id_use_rs && mem_hit_rs) fwd_a_sel_d = 2'd2;
      if (id_use_rt && ex_hit_rt)       fwd_b_sel_d = 2'd1;
      else if (id_use_rt && mem_hit_rt) fwd_b_sel_d = 2'd2;
    end
  end

  // Shift the stage slots EX->MEM and register the selects into EX.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_dst_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_dst_q   <= '0;
      fwd_a_sel_q <= 2'd0;
      fwd_b_sel_q <= 2'd0;
    end else begin
      ex_we_q     <= ex_we_d;
      ex_load_q   <= ex_load_d;
      ex_dst_q    <= ex_dst_d;
      mem_we_q    <= ex_we_q;
      mem_dst_q   <= ex_dst_q;
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
    end
  end

  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;

`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating counters: stall cycles, and EX entries using any forward path.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (((fwd_a_sel_d != 2'd0) || (fwd_b_sel_d != 2'd0)) && (fwd_cnt_q != '1))
      fwd_cnt_d = fwd_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// tb/tb_fwd_ctrl_unit.sv - directed self-checking bench for fwd_ctrl_unit
module tb_fwd_ctrl_unit;

  logic       Clk;
  logic       Rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt, id_we, id_load;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fwd_ctrl_unit dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_we     (id_we),
    .id_dst    (id_dst),
    .id_load   (id_load),
    .flush     (flush),
    .stall     (stall),
    .fwd_a_sel (fwd_a_sel),
    .fwd_b_sel (fwd_b_sel)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [4:0] dst, input logic ld);
    id_valid  = v;
    id_rs     = rs;
    id_rt     = rt;
    id_use_rs = urs;
    id_use_rt = urt;
    id_we     = we;
    id_dst    = dst;
    id_load   = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    nop();
    step();
    step();
  endtask

  initial begin
    Rst_n = 1'b0;
    flush = 1'b0;
    nop();
    step();
    step();
    chk("rst_stall", stall, 0);
    chk("rst_sel_a", fwd_a_sel, 0);
    chk("rst_sel_b", fwd_b_sel, 0);
`ifdef FWD_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_fwd_cnt", fwd_cnt, 0);
`endif
    @(negedge Clk);
    Rst_n = 1'b1;

    // NOP stream with id_valid=0 but register fields that would otherwise match
    for (int i = 0; i < 4; i++) begin
      set_id(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1);
      #1;
      chk("nop_stall", stall, 0);
      step();
      chk("nop_sel_a", fwd_a_sel, 0);
      chk("nop_sel_b", fwd_b_sel, 0);
    end
    drain();

    // add $8,$9,$10 ; sub $11,$8,$12 -> EX forward on A
    set_id(1, 9, 10, 1, 1, 1, 8, 0);
    step();
    set_id(1, 8, 12, 1, 1, 1, 11, 0);
    #1;
    chk("exfwd_stall", stall, 0);
    step();
    chk("exfwd_sel_a", fwd_a_sel, 1);
    chk("exfwd_sel_b", fwd_b_sel, 0);
    drain();

    // add $8 ; add $13,$1,$2 ; sub $11,$8,$12 -> MEM forward on A
    set_id(1, 9, 10, 1, 1, 1, 8, 0);
    step();
    set_id(1, 1, 2, 1, 1, 1, 13, 0);
    step();
    chk("indep_sel_a", fwd_a_sel, 0);
    set_id(1, 8, 12, 1, 1, 1, 11, 0);
    step();
    chk("memfwd_sel_a", fwd_a_sel, 2);
    chk("memfwd_sel_b", fwd_b_sel, 0);
    drain();

    // lw $8,0($4) ; add $9,$8,$8 -> one stall cycle, then MEM forward on both
    set_id(1, 4, 0, 1, 0, 1, 8, 1);
    step();
    set_id(1, 8, 8, 1, 1, 1, 9, 0);
    #1;
    chk("lu_stall_on", stall, 1);
    step();
    chk("lu_bubble_sel_a", fwd_a_sel, 0);
    chk("lu_stall_off", stall, 0);
    step();
    chk("lu_sel_a", fwd_a_sel, 2);
    chk("lu_sel_b", fwd_b_sel, 2);
    drain();

    // add $0,$1,$2 ; sub $5,$0,$0 ; lw $0 ; add $9,$0,$0 -> nothing forwarded, no stall
    set_id(1, 1, 2, 1, 1, 1, 0, 0);
    step();
    set_id(1, 0, 0, 1, 1, 1, 5, 0);
    step();
    chk("r0_sel_a", fwd_a_sel, 0);
    chk("r0_sel_b", fwd_b_sel, 0);
    set_id(1, 4, 0, 1, 0, 1, 0, 1);
    step();
    set_id(1, 0, 0, 1, 1, 1, 9, 0);
    #1;
    chk("r0_load_stall", stall, 0);
    step();
    chk("r0_load_sel_a", fwd_a_sel, 0);
    chk("r0_load_sel_b", fwd_b_sel, 0);
    drain();

    // add $8 ; add $8 ; sub $5,$8,$0 -> nearest producer wins
    set_id(1, 1, 2, 1, 1, 1, 8, 0);
    step();
    set_id(1, 3, 4, 1, 1, 1, 8, 0);
    step();
    set_id(1, 8, 0, 1, 1, 1, 5, 0);
    step();
    chk("near_sel_a", fwd_a_sel, 1);
    chk("near_sel_b", fwd_b_sel, 0);
    drain();

    // lw $8 ; dependent add with flush -> no stall, bubble enters EX
    set_id(1, 4, 0, 1, 0, 1, 8, 1);
    step();
    set_id(1, 8, 1, 1, 1, 1, 9, 0);
    flush = 1'b1;
    #1;
    chk("flush_ld_stall", stall, 0);
    step();
    flush = 1'b0;
    chk("flush_ld_sel_a", fwd_a_sel, 0);
    drain();

    // add $8 ; sub $11,$8,$12 flushed -> bubble selects stay 0
    set_id(1, 9, 10, 1, 1, 1, 8, 0);
    step();
    set_id(1, 8, 8, 1, 1, 1, 11, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_alu_sel_a", fwd_a_sel, 0);
    chk("flush_alu_sel_b", fwd_b_sel, 0);
    drain();

    // Reset asserted during a load-use stall drops stall asynchronously
    set_id(1, 4, 0, 1, 0, 1, 8, 1);
    step();
    set_id(1, 8, 8, 1, 1, 1, 9, 0);
    #1;
    chk("rststall_on", stall, 1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("rststall_off", stall, 0);
    chk("rststall_sel_a", fwd_a_sel, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    nop();
    step();
`ifdef FWD_STATS_EN
    chk("rststall_cnt", stall_cnt, 0);
`endif

    // lw $8 ; lw $9,0($8) ; add $10,$9,$0 -> two separate 1-cycle stalls
    set_id(1, 4, 0, 1, 0, 1, 8, 1);
    step();
    set_id(1, 8, 0, 1, 0, 1, 9, 1);
    #1;
    chk("b2b_stall1_on", stall, 1);
    step();
    chk("b2b_stall1_off", stall, 0);
    step();
    chk("b2b_ld_sel_a", fwd_a_sel, 2);
    set_id(1, 9, 0, 1, 1, 1, 10, 0);
    #1;
    chk("b2b_stall2_on", stall, 1);
    step();
    chk("b2b_stall2_off", stall, 0);
    step();
    chk("b2b_add_sel_a", fwd_a_sel, 2);
    chk("b2b_add_sel_b", fwd_b_sel, 0);
    drain();
`ifdef FWD_STATS_EN
    chk("end_stall_cnt", stall_cnt, 2);
    chk("end_fwd_cnt", fwd_cnt, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
